// File: rtl/pll_dri_if.sv
`timescale 1ns/1ps
// Host command/response channel plus PF_CCC DRI port of the PLL DRI initiator.
// The master modport is the initiator's view; slave is the host/PLL side.
interface pll_dri_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        cmd_relock;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [10:0] dri_ctrl;
    logic [32:0] dri_wdata;
    logic [32:0] dri_rdata;
    logic        dri_interrupt;
    logic        irq_clr;
    logic        irq_pending;
    logic        pll_lock;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_relock,
        input  dri_rdata, dri_interrupt, irq_clr, pll_lock,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output dri_ctrl, dri_wdata, irq_pending
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_relock,
        output dri_rdata, dri_interrupt, irq_clr, pll_lock,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  dri_ctrl, dri_wdata, irq_pending
    );
endinterface

// File: rtl/pll_dri_master.sv
`timescale 1ns/1ps
// DRI initiator: turns single host register commands into APB-style DRI transfers,
// optionally waits for a stable PLL relock after a write, then returns one response.
module pll_dri_master #(
    parameter int TIMEOUT_CYCLES      = 256,
    parameter int LOCK_TIMEOUT_CYCLES = 4096,
    parameter int LOCK_STABLE_CYCLES  = 16
) (
    input  logic      clk,
    input  logic      rst,
    pll_dri_if.master bus
);
    localparam int ACC_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LTO_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int STB_W = $clog2(LOCK_STABLE_CYCLES + 1);

    localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LTO_W-1:0] LTO_LAST = LTO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);

    localparam logic [1:0] ERR_OK     = 2'b00;
    localparam logic [1:0] ERR_PREADY = 2'b01;
    localparam logic [1:0] ERR_LOCK   = 2'b10;

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, LOCKWAIT, RESP} state_t;

    state_t            state, state_n;
    logic              cmd_ready_q;
    logic              write_q;
    logic              relock_q;
    logic [7:0]        addr_q;
    logic [31:0]       wdata_q;
    logic [ACC_W-1:0]  acc_cnt;
    logic [LTO_W-1:0]  lock_cnt;
    logic [STB_W-1:0]  stable_cnt;
    logic              lock_meta;
    logic              lock_sync;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic [1:0]        rsp_err_q;
    logic              irq_q;
    logic              accept;
    logic              rsp_load;
    logic [31:0]       rdata_n;
    logic [1:0]        err_n;
    logic              pready;
    logic [31:0]       prdata;
    logic [10:0]       ctrl;
    logic [32:0]       wdata_out;

    function automatic int unsigned sat_inc(input int unsigned v, input int unsigned lim);
        return (v < lim) ? v + 1 : lim;
    endfunction

    assign pready = bus.dri_rdata[32];
    assign prdata = bus.dri_rdata[31:0];
    assign accept = bus.cmd_valid && cmd_ready_q;

    // DRI strobes decode straight from the state register so an async reset drops them at once.
    always_comb begin
        state_n   = state;
        rsp_load  = 1'b0;
        rdata_n   = '0;
        err_n     = ERR_OK;
        ctrl      = '0;
        wdata_out = '0;
        case (state)
            IDLE: begin
                if (accept) state_n = SETUP;
            end
            SETUP: begin
                ctrl      = {addr_q, write_q, 1'b0, 1'b1};
                wdata_out = {1'b0, wdata_q};
                state_n   = ACCESS;
            end
            ACCESS: begin
                ctrl      = {addr_q, write_q, 1'b1, 1'b1};
                wdata_out = {1'b0, wdata_q};
                if (pready) begin
                    if (relock_q) begin
                        state_n = LOCKWAIT;
                    end else begin
                        state_n  = RESP;
                        rsp_load = 1'b1;
                        rdata_n  = write_q ? 32'd0 : prdata;
                    end
                end else if (acc_cnt == ACC_LAST) begin
                    state_n  = RESP;
                    rsp_load = 1'b1;
                    err_n    = ERR_PREADY;
                end
            end
            LOCKWAIT: begin
                if (lock_sync && stable_cnt == STB_LAST) begin
                    state_n  = RESP;
                    rsp_load = 1'b1;
                end else if (lock_cnt == LTO_LAST) begin
                    state_n  = RESP;
                    rsp_load = 1'b1;
                    err_n    = ERR_LOCK;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cmd_ready_q <= 1'b0;
            write_q     <= 1'b0;
            relock_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            acc_cnt     <= '0;
            lock_cnt    <= '0;
            stable_cnt  <= '0;
            lock_meta   <= 1'b0;
            lock_sync   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= ERR_OK;
            irq_q       <= 1'b0;
        end else begin
            state       <= state_n;
            cmd_ready_q <= (state_n == IDLE);
            if (accept) begin
                write_q  <= bus.cmd_write;
                relock_q <= bus.cmd_write && bus.cmd_relock;
                addr_q   <= bus.cmd_addr;
                wdata_q  <= bus.cmd_wdata;
            end
            // Counters restart on every state entry and saturate rather than wrap.
            acc_cnt    <= (state == ACCESS) ? ACC_W'(sat_inc(32'(acc_cnt), TIMEOUT_CYCLES)) : '0;
            lock_cnt   <= (state == LOCKWAIT) ? LTO_W'(sat_inc(32'(lock_cnt), LOCK_TIMEOUT_CYCLES)) : '0;
            stable_cnt <= (state == LOCKWAIT && lock_sync) ?
                          STB_W'(sat_inc(32'(stable_cnt), LOCK_STABLE_CYCLES)) : '0;
            lock_meta   <= bus.pll_lock;
            lock_sync   <= lock_meta;
            rsp_valid_q <= rsp_load;
            if (rsp_load) begin
                rsp_rdata_q <= rdata_n;
                rsp_err_q   <= err_n;
            end
            irq_q <= bus.dri_interrupt | (irq_q & ~bus.irq_clr);
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.dri_ctrl    = ctrl;
    assign bus.dri_wdata   = wdata_out;
    assign bus.irq_pending = irq_q;
endmodule

// File: tb/tb_pll_dri_master.sv
`timescale 1ns/1ps
// Directed bench for pll_dri_master: a DRI slave model with programmable wait states,
// a response scoreboard, and explicit checks of DRI strobes, timeouts, relock and IRQ.
module tb_pll_dri_master;
    logic clk = 1'b0;
    logic rst = 1'b1;

    pll_dri_if bus ();

    pll_dri_master #(
        .TIMEOUT_CYCLES(256),
        .LOCK_TIMEOUT_CYCLES(4096),
        .LOCK_STABLE_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  err;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          slave_wait = 0;
    int          acc_count = 0;
    logic [31:0] prdata = 32'd0;
    logic        pready;

    // Slave model: PREADY rises on ACCESS cycle number slave_wait (0-based).
    always @(posedge clk) acc_count <= (bus.dri_ctrl[1:0] == 2'b11) ? acc_count + 1 : 0;
    assign pready = (bus.dri_ctrl[1:0] == 2'b11) && (acc_count == slave_wait);
    assign bus.dri_rdata = {pready, prdata};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [7:0] addr, input logic [31:0] wd, input logic rl);
        chk("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_write  = wr;
        bus.cmd_addr   = addr;
        bus.cmd_wdata  = wd;
        bus.cmd_relock = rl;
        bus.cmd_valid  = 1'b1;
        tick();
        bus.cmd_valid  = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] r, input logic [1:0] e);
        exp_q.push_back({r, e});
    endtask

    task automatic wait_rsp(input string tag, input int budget, output int cyc);
        exp_t e;
        cyc = 0;
        while (bus.rsp_valid !== 1'b1 && cyc < budget) begin
            tick();
            cyc++;
        end
        if (bus.rsp_valid === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_rdata"}, 64'(bus.rsp_rdata), 64'(e.rdata));
            chk({tag, "_err"}, 64'(bus.rsp_err), 64'(e.err));
        end else begin
            chk({tag, "_rsp_seen"}, 64'({bus.rsp_valid, exp_q.size() > 0}), 64'd3);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        logic seen;
        bus.cmd_valid     = 1'b0;
        bus.cmd_write     = 1'b0;
        bus.cmd_addr      = 8'd0;
        bus.cmd_wdata     = 32'd0;
        bus.cmd_relock    = 1'b0;
        bus.dri_interrupt = 1'b0;
        bus.irq_clr       = 1'b0;
        bus.pll_lock      = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_ready", 64'(bus.cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        chk("rst_ctrl", 64'(bus.dri_ctrl), 64'd0);
        chk("rst_wdata", 64'(bus.dri_wdata), 64'd0);
        chk("rst_irq", 64'(bus.irq_pending), 64'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", 64'(bus.cmd_ready), 64'd1);

        // 1: read, PREADY on first ACCESS cycle
        slave_wait = 0;
        prdata = 32'hA5A5_1234;
        issue(1'b0, 8'h05, 32'h0, 1'b0);
        push_exp(32'hA5A5_1234, 2'b00);
        chk("rd_setup_ctrl", 64'(bus.dri_ctrl), 64'h029);
        tick();
        chk("rd_access_ctrl", 64'(bus.dri_ctrl), 64'h02B);
        wait_rsp("rd", 10, cyc);
        chk("rd_latency", 64'(cyc + 2), 64'd3);
        chk("rd_ctrl_idle", 64'(bus.dri_ctrl), 64'd0);
        tick();
        chk("rd_valid_pulse", 64'(bus.rsp_valid), 64'd0);
        chk("rd_rdata_hold", 64'(bus.rsp_rdata), 64'hA5A5_1234);

        // 2: write with 5 wait states, commands during busy ignored
        slave_wait = 5;
        issue(1'b1, 8'h10, 32'hDEAD_BEEF, 1'b0);
        push_exp(32'h0, 2'b00);
        chk("wr_setup_ctrl", 64'(bus.dri_ctrl), 64'h085);
        chk("wr_setup_wdata", 64'(bus.dri_wdata), 64'h0_DEAD_BEEF);
        tick();
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h55;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("wr_access_ctrl", 64'(bus.dri_ctrl), 64'h087);
            chk("wr_access_wdata", 64'(bus.dri_wdata), 64'h0_DEAD_BEEF);
            chk("wr_busy_ready", 64'(bus.cmd_ready), 64'd0);
            if (i == 3) bus.cmd_valid = 1'b0;
        end
        wait_rsp("wr", 10, cyc);
        chk("wr_latency", 64'(cyc), 64'd1);
        chk("wr_ctrl_idle", 64'(bus.dri_ctrl), 64'd0);
        chk("wr_wdata_idle", 64'(bus.dri_wdata), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen = seen | bus.rsp_valid;
        end
        chk("busy_cmd_ignored", 64'(seen), 64'd0);

        // 3: PREADY timeout, then PREADY on the final counted cycle
        slave_wait = 100000;
        prdata = 32'h1357_9BDF;
        issue(1'b0, 8'h33, 32'h0, 1'b0);
        push_exp(32'h0, 2'b01);
        wait_rsp("rd_timeout", 400, cyc);
        chk("rd_timeout_latency", 64'(cyc), 64'd257);
        chk("rd_timeout_psel", 64'(bus.dri_ctrl), 64'd0);
        tick();
        slave_wait = 255;
        prdata = 32'h0BAD_F00D;
        issue(1'b0, 8'h34, 32'h0, 1'b0);
        push_exp(32'h0BAD_F00D, 2'b00);
        wait_rsp("rd_last_cycle", 400, cyc);
        chk("rd_last_latency", 64'(cyc), 64'd257);
        tick();

        // 4: relock write with a glitching lock, then a lock that never returns
        slave_wait = 0;
        bus.pll_lock = 1'b0;
        repeat (3) tick();
        issue(1'b1, 8'h20, 32'h0000_00C3, 1'b1);
        push_exp(32'h0, 2'b00);
        repeat (4) tick();
        chk("relock_ctrl_idle", 64'(bus.dri_ctrl), 64'd0);
        bus.pll_lock = 1'b1;
        repeat (5) tick();
        bus.pll_lock = 1'b0;
        repeat (4) tick();
        chk("relock_no_early_rsp", 64'(bus.rsp_valid), 64'd0);
        bus.pll_lock = 1'b1;
        wait_rsp("relock_ok", 40, cyc);
        chk("relock_latency", 64'(cyc), 64'd18);
        tick();
        bus.pll_lock = 1'b0;
        repeat (3) tick();
        issue(1'b1, 8'h21, 32'h0000_0001, 1'b1);
        push_exp(32'h0, 2'b10);
        wait_rsp("lock_timeout", 5000, cyc);
        chk("lock_timeout_latency", 64'(cyc), 64'd4098);
        bus.pll_lock = 1'b1;
        tick();

        // 5: reset during ACCESS aborts silently, next command completes
        slave_wait = 100000;
        issue(1'b0, 8'h07, 32'h0, 1'b0);
        repeat (3) tick();
        chk("abort_access_ctrl", 64'(bus.dri_ctrl), 64'h03B);
        rst = 1'b1;
        #1;
        chk("abort_ctrl_async", 64'(bus.dri_ctrl), 64'd0);
        chk("abort_ready", 64'(bus.cmd_ready), 64'd0);
        tick();
        tick();
        chk("abort_no_rsp", 64'(bus.rsp_valid), 64'd0);
        rst = 1'b0;
        chk("abort_ready_low", 64'(bus.cmd_ready), 64'd0);
        tick();
        chk("abort_ready_high", 64'(bus.cmd_ready), 64'd1);
        chk("abort_no_rsp_after", 64'(bus.rsp_valid), 64'd0);
        slave_wait = 0;
        prdata = 32'h7E57_0042;
        issue(1'b0, 8'h09, 32'h0, 1'b1);
        push_exp(32'h7E57_0042, 2'b00);
        wait_rsp("post_rst_rd", 20, cyc);
        chk("post_rst_latency", 64'(cyc + 1), 64'd3);
        tick();

        // 6: interrupt capture and clear
        bus.dri_interrupt = 1'b1;
        tick();
        bus.dri_interrupt = 1'b0;
        chk("irq_set", 64'(bus.irq_pending), 64'd1);
        repeat (3) tick();
        chk("irq_sticky", 64'(bus.irq_pending), 64'd1);
        bus.irq_clr = 1'b1;
        tick();
        bus.irq_clr = 1'b0;
        chk("irq_cleared", 64'(bus.irq_pending), 64'd0);
        bus.dri_interrupt = 1'b1;
        bus.irq_clr = 1'b1;
        tick();
        bus.dri_interrupt = 1'b0;
        bus.irq_clr = 1'b0;
        chk("irq_set_wins", 64'(bus.irq_pending), 64'd1);
        tick();
        chk("irq_hold", 64'(bus.irq_pending), 64'd1);
        bus.irq_clr = 1'b1;
        tick();
        bus.irq_clr = 1'b0;
        chk("irq_cleared2", 64'(bus.irq_pending), 64'd0);

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
